fb_bank_ctrl: RTL and testbench
===============================

// Module: fb_bank_ctrl
// PURPOSE
// - Local-bus decoder between the AXI4-Lite slave's local port and a two-bank frame RAM.
// - The CPU writes and reads the back bank. The display scanner reads the front bank.
// - Banks swap only at a display frame boundary, on CPU request (tear-free double buffering).
// - Also holds the control/status registers (enable, brightness, swap, frame counter) consumed by the display stage.
// PARAMETERS
// - ADDR_W   14  local byte-address width; MSB=0 selects pixel RAM, MSB=1 selects registers
// - RAM_AW   11  word address width per bank (2^RAM_AW pixels/bank); must equal ADDR_W-3
// PORTS
// - axi_clk          in   1         system clock, all logic on rising edge
// - axi_rst          in   1         synchronous, active-high reset
// - local_addr       in   ADDR_W    byte address from AXI4-Lite slave
// - local_wr_data    in   32        write data
// - local_wr         in   1         one-cycle write strobe
// - local_rd_data    out  32        read data (combinational from local_addr)
// - ram_we           out  1         frame RAM write enable
// - ram_addr         out  RAM_AW+1  {bank, word} for CPU port of frame RAM
// - ram_wdata        out  24        RGB888 write data
// - ram_rdata        in   24        async read data from CPU port of frame RAM
// - disp_frame_done  in   1         one-cycle pulse from display at end of frame
// - disp_bank        out  1         front bank; display prepends it to its read address
// - disp_enable      out  1         CTRL[0]
// - disp_brightness  out  8         CTRL[15:8]
// - irq              out  1         swap-complete interrupt (only with SWAP_IRQ_EN)
// BEHAVIOUR
// Address map:
// - RAM window: local_addr[ADDR_W-1]=0, word = local_addr[ADDR_W-2:2].
// - Registers: offsets local_addr[3:0]. 0x0 CTRL rw, 0x4 SWAP wo, 0x8 STATUS ro, 0xC IRQ rw1c. Other offsets read 0; writes to them are ignored.
// RAM path (combinational):
// - ram_addr = {~front_bank, word}.
// - ram_we = local_wr & RAM window.
// - ram_wdata = local_wr_data[23:0].
// - RAM reads return {8'h00, ram_rdata}.
// - ram_addr uses the current registered front_bank. A write in the swap cycle lands in the old back bank.
// Registers:
// - CTRL[0] enable, CTRL[15:8] brightness; reset 0 and 8'h00. Unused bits read 0.
// - STATUS[0] swap_pending, [1] front_bank, [31:16] frame_count.
// - frame_count increments on every disp_frame_done and wraps 0xFFFF->0x0000.
// Swap FSM:
// - States: IDLE, PENDING.
// - IDLE: a write to SWAP with data[0]=1 moves to PENDING on the next clock. data[0]=0 is ignored.
// - PENDING: on disp_frame_done, front_bank toggles and the FSM returns to IDLE in the same clock edge.
// - A SWAP write while PENDING has no effect. A second swap is never queued.
// - SWAP write and disp_frame_done in the same cycle while IDLE: go to PENDING; no swap on that pulse.
// - Swap proceeds regardless of CTRL enable.
// Reset values:
// - state IDLE, front_bank=0 (CPU owns bank 1), frame_count=0.
// - disp_enable=0, disp_brightness=0, disp_bank=0, irq=0.
// - Reset asserted mid-PENDING drops the request.
// Outputs:
// - disp_bank, disp_enable and disp_brightness come directly from registers (no combinational path from inputs).
// CONFIGURATION
// - SWAP_IRQ_EN defined:
//   - irq port present. irq = irq_flag & irq_mask; level output.
//   - irq_flag is set on each completed swap.
//   - IRQ reg: [0] flag, write 1 clears; [1] mask rw, reset 0.
//   - Set and clear in the same cycle: set wins.
// - SWAP_IRQ_EN undefined:
//   - No irq port; offset 0xC reads 0 and writes are ignored.
// TESTING
// - Reset, read STATUS -> 0x0000_0000; read CTRL -> 0. disp_bank=0, disp_enable=0.
// - Write 0x0000_0123 to 0x0010 -> ram_we=1, ram_addr={1'b1,11'd4}, ram_wdata=24'h000123. Read 0x0010 returns {8'h0, ram_rdata}.
// - Write SWAP=1, STATUS[0]=1; pulse disp_frame_done -> disp_bank=1, STATUS=0x0001_0002. Next write to 0x0 targets bank 0.
// - SWAP write coincident with disp_frame_done in IDLE -> no toggle, PENDING; next pulse toggles. Second SWAP while PENDING -> still one toggle.
// - Issue 65536 frame_done pulses -> frame_count wraps to 0; write CTRL=0x0000_AB01 -> disp_brightness=8'hAB, disp_enable=1.
// - SWAP_IRQ_EN: mask=1, complete swap -> irq=1; write IRQ=0x3 -> irq=0. Clear in the swap cycle -> irq stays 1.

Source files
------------

// File: rtl/fb_bank_ctrl.sv
// fb_bank_ctrl: frame RAM bank decoder, tear-free swap FSM and CSRs; define SWAP_IRQ_EN for the swap-complete irq
module fb_bank_ctrl #(
  parameter int ADDR_W = 14,
  parameter int RAM_AW = 11
) (
  input  logic              axi_clk,
  input  logic              axi_rst,
  input  logic [ADDR_W-1:0] local_addr,
  input  logic [31:0]       local_wr_data,
  input  logic              local_wr,
  output logic [31:0]       local_rd_data,
  output logic              ram_we,
  output logic [RAM_AW:0]   ram_addr,
  output logic [23:0]       ram_wdata,
  input  logic [23:0]       ram_rdata,
  input  logic              disp_frame_done,
  output logic              disp_bank,
  output logic              disp_enable,
  output logic [7:0]        disp_brightness
`ifdef SWAP_IRQ_EN
  ,output logic             irq
`endif
);
  typedef enum logic {IDLE, PENDING} state_t;
  state_t state;
  logic front_bank;
  logic [15:0] frame_count;
  logic reg_sel, wr_ctrl, wr_swap, swap_done;
  logic [3:0] off;
  logic [31:0] irq_rd;
  logic unused_bits;
  assign reg_sel = local_addr[ADDR_W-1];
  assign off = local_addr[3:0];
  assign wr_ctrl = local_wr & reg_sel & (off == 4'h0);
  assign wr_swap = local_wr & reg_sel & (off == 4'h4);
  assign swap_done = (state == PENDING) & disp_frame_done;
  assign unused_bits = ^{local_addr[1:0], local_wr_data[31:24]};
  // CPU always addresses the back bank, i.e. the one the display is not scanning
  assign ram_addr = {~front_bank, local_addr[ADDR_W-2:2]};
  assign ram_we = local_wr & ~reg_sel;
  assign ram_wdata = local_wr_data[23:0];
  assign disp_bank = front_bank;
  always_comb begin
    local_rd_data = 32'h0;
    if (!reg_sel) local_rd_data = {8'h00, ram_rdata};
    else if (off == 4'h0) local_rd_data = {16'h0, disp_brightness, 7'h0, disp_enable};
    else if (off == 4'h8) local_rd_data = {frame_count, 14'h0, front_bank, state == PENDING};
    else if (off == 4'hC) local_rd_data = irq_rd;
  end
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state <= IDLE;
      front_bank <= 1'b0;
      frame_count <= 16'h0;
      disp_enable <= 1'b0;
      disp_brightness <= 8'h00;
    end else begin
      frame_count <= frame_count + {15'h0, disp_frame_done};
      if (wr_ctrl) begin
        disp_enable <= local_wr_data[0];
        disp_brightness <= local_wr_data[15:8];
      end
      case (state)
        IDLE: if (wr_swap && local_wr_data[0]) state <= PENDING;
        PENDING: if (disp_frame_done) begin
          front_bank <= ~front_bank;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SWAP_IRQ_EN
  logic irq_flag, irq_mask, wr_irq;
  assign wr_irq = local_wr & reg_sel & (off == 4'hC);
  assign irq = irq_flag & irq_mask;
  assign irq_rd = {30'h0, irq_mask, irq_flag};
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      irq_flag <= 1'b0;
      irq_mask <= 1'b0;
    end else begin
      irq_flag <= swap_done | (irq_flag & ~(wr_irq & local_wr_data[0]));
      if (wr_irq) irq_mask <= local_wr_data[1];
    end
  end
`else
  assign irq_rd = 32'h0;
`endif
endmodule

// File: tb/tb_fb_bank_ctrl.sv
// tb_fb_bank_ctrl: directed self-checking bench for fb_bank_ctrl
module tb_fb_bank_ctrl;
  logic axi_clk = 1'b0;
  logic axi_rst = 1'b1;
  logic [13:0] local_addr = '0;
  logic [31:0] local_wr_data = '0;
  logic local_wr = 1'b0;
  logic [31:0] local_rd_data;
  logic ram_we;
  logic [11:0] ram_addr;
  logic [23:0] ram_wdata;
  logic [23:0] ram_rdata = 24'hABCDEF;
  logic disp_frame_done = 1'b0;
  logic disp_bank, disp_enable;
  logic [7:0] disp_brightness;
`ifdef SWAP_IRQ_EN
  logic irq;
`endif
  int tests = 0;
  int fails = 0;

  fb_bank_ctrl dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst), .local_addr(local_addr),
    .local_wr_data(local_wr_data), .local_wr(local_wr), .local_rd_data(local_rd_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .disp_frame_done(disp_frame_done), .disp_bank(disp_bank), .disp_enable(disp_enable),
    .disp_brightness(disp_brightness)
`ifdef SWAP_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 axi_clk = ~axi_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    @(negedge axi_clk);
    local_addr = a;
    local_wr_data = d;
    local_wr = 1'b1;
    @(negedge axi_clk);
    local_wr = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [13:0] a, input logic [31:0] exp);
    local_addr = a;
    #1;
    chk(tag, local_rd_data, exp);
  endtask

  task automatic pulse();
    @(negedge axi_clk);
    disp_frame_done = 1'b1;
    @(negedge axi_clk);
    disp_frame_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge axi_clk);
    axi_rst = 1'b1;
    @(negedge axi_clk);
    axi_rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge axi_clk);
    axi_rst = 1'b0;
    rd("rst_status", 14'h2008, 32'h0);
    rd("rst_ctrl", 14'h2000, 32'h0);
    chk("rst_bank", {31'h0, disp_bank}, 32'h0);
    chk("rst_en", {31'h0, disp_enable}, 32'h0);
    chk("rst_bright", {24'h0, disp_brightness}, 32'h0);
    @(negedge axi_clk);
    local_addr = 14'h0010;
    local_wr_data = 32'hFF00_0123;
    local_wr = 1'b1;
    #1;
    chk("ram_we", {31'h0, ram_we}, 32'h1);
    chk("ram_addr", {20'h0, ram_addr}, 32'h804);
    chk("ram_wdata", {8'h0, ram_wdata}, 32'h000123);
    @(negedge axi_clk);
    local_wr = 1'b0;
    #1;
    chk("ram_we_idle", {31'h0, ram_we}, 32'h0);
    rd("ram_rd", 14'h0010, 32'h00AB_CDEF);
    local_addr = 14'h2000;
    local_wr_data = 32'h0;
    local_wr = 1'b1;
    #1;
    chk("reg_no_ram_we", {31'h0, ram_we}, 32'h0);
    @(negedge axi_clk);
    local_wr = 1'b0;
    wr(14'h2004, 32'h1);
    rd("swap_pending", 14'h2008, 32'h0000_0001);
    pulse();
    rd("swap_done", 14'h2008, 32'h0001_0002);
    chk("disp_bank1", {31'h0, disp_bank}, 32'h1);
    local_addr = 14'h0000;
    #1;
    chk("ram_addr_b0", {20'h0, ram_addr}, 32'h000);
    wr(14'h2004, 32'h2);
    rd("swap_d0_ignored", 14'h2008, 32'h0001_0002);
    @(negedge axi_clk);
    local_addr = 14'h2004;
    local_wr_data = 32'h1;
    local_wr = 1'b1;
    disp_frame_done = 1'b1;
    @(negedge axi_clk);
    local_wr = 1'b0;
    disp_frame_done = 1'b0;
    rd("coincident", 14'h2008, 32'h0002_0003);
    wr(14'h2004, 32'h1);
    rd("swap_while_pend", 14'h2008, 32'h0002_0003);
    pulse();
    rd("one_toggle", 14'h2008, 32'h0003_0000);
    chk("disp_bank0", {31'h0, disp_bank}, 32'h0);
    pulse();
    rd("no_queue", 14'h2008, 32'h0004_0000);
    wr(14'h2004, 32'h1);
    rd("pend_again", 14'h2008, 32'h0004_0001);
    do_reset();
    rd("rst_drops_pend", 14'h2008, 32'h0);
    pulse();
    rd("no_swap_after_rst", 14'h2008, 32'h0001_0000);
    do_reset();
    @(negedge axi_clk);
    disp_frame_done = 1'b1;
    repeat (65535) @(negedge axi_clk);
    disp_frame_done = 1'b0;
    rd("count_ffff", 14'h2008, 32'hFFFF_0000);
    pulse();
    rd("count_wrap", 14'h2008, 32'h0);
    wr(14'h2000, 32'h0000_AB01);
    #1;
    chk("bright_ab", {24'h0, disp_brightness}, 32'hAB);
    chk("enable_1", {31'h0, disp_enable}, 32'h1);
    rd("ctrl_rd", 14'h2000, 32'h0000_AB01);
    wr(14'h2000, 32'hFFFF_FFFF);
    rd("ctrl_mask", 14'h2000, 32'h0000_FF01);
    rd("swap_rd0", 14'h2004, 32'h0);
    rd("off1_rd0", 14'h2001, 32'h0);
    wr(14'h2004, 32'h1);
    pulse();
    rd("swap_while_en", 14'h2008, 32'h0001_0002);
`ifdef SWAP_IRQ_EN
    rd("irq_flag", 14'h200C, 32'h1);
    chk("irq_masked", {31'h0, irq}, 32'h0);
    wr(14'h200C, 32'h3);
    wr(14'h200C, 32'h2);
    wr(14'h2004, 32'h1);
    pulse();
    #1;
    chk("irq_set", {31'h0, irq}, 32'h1);
    wr(14'h200C, 32'h3);
    #1;
    chk("irq_clr", {31'h0, irq}, 32'h0);
    rd("irq_reg", 14'h200C, 32'h2);
    wr(14'h2004, 32'h1);
    @(negedge axi_clk);
    local_addr = 14'h200C;
    local_wr_data = 32'h3;
    local_wr = 1'b1;
    disp_frame_done = 1'b1;
    @(negedge axi_clk);
    local_wr = 1'b0;
    disp_frame_done = 1'b0;
    #1;
    chk("irq_set_wins", {31'h0, irq}, 32'h1);
`else
    rd("irq_off_rd0", 14'h200C, 32'h0);
    wr(14'h200C, 32'h3);
    rd("irq_off_wr", 14'h200C, 32'h0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
